// File: rtl/bubble_output_serializer_pkg.sv
// rtl/bubble_output_serializer_pkg.sv - shared encodings and defaults for the bubble output serializer
package bubble_output_serializer_pkg;

  localparam int unsigned CYC_W = 13;
  localparam int unsigned LAT_W = 3;

  // Emulator access types presented by the timing generator
  typedef enum logic [2:0] {
    ACC_RST  = 3'b000,
    ACC_STBY = 3'b001,
    ACC_IDLE = 3'b100,
    ACC_BOOT = 3'b110,
    ACC_USER = 3'b111
  } acctype_e;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } fetch_state_e;

  localparam logic [CYC_W-1:0] INVALID_CYCLE_DEF = 13'd8191;
  localparam logic [CYC_W-1:0] BOOT_BASE_DEF     = 13'd0;
  localparam logic [CYC_W-1:0] PAGE_BASE_DEF     = 13'd4352;
  localparam logic [1:0]       DATA_TICK         = 2'b10;

endpackage

// File: rtl/bubble_fetch_latency_counter.sv
// rtl/bubble_fetch_latency_counter.sv - down-counter timing the buffer RAM read latency
module bubble_fetch_latency_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  // A reload always wins so a reissued fetch restarts the latency window
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/bubble_output_serializer.sv
// rtl/bubble_output_serializer.sv - fetches one nibble per bubble output cycle and drives nDOUT in the data window
module bubble_output_serializer
  import bubble_output_serializer_pkg::*;
#(
  parameter int unsigned      RAM_LATENCY   = 2,
  parameter logic [CYC_W-1:0] BOOT_BASE     = BOOT_BASE_DEF,
  parameter logic [CYC_W-1:0] PAGE_BASE     = PAGE_BASE_DEF,
  parameter logic [CYC_W-1:0] INVALID_CYCLE = INVALID_CYCLE_DEF
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic [2:0]       ACCTYPE,
  input  logic [CYC_W-1:0] BOUTCYCLENUM,
  input  logic [1:0]       BOUTTICKS,
  output logic             RD_EN,
  output logic [CYC_W-1:0] RD_ADDR,
  input  logic [3:0]       RD_DATA,
  output logic [3:0]       nDOUT,
  output logic             UNDERRUN,
  output logic             BUSY
);

  fetch_state_e     state_q, state_d;
  logic [CYC_W-1:0] last_cycle_q;
  logic             rd_en_q, rd_en_d;
  logic [CYC_W-1:0] rd_addr_q, rd_addr_d;
  logic             busy_q, busy_d;
  logic [3:0]       ndout_q, ndout_d;
  logic             underrun_q, underrun_d;
  logic [3:0]       staged_q, staged_d;
  logic             staged_valid_q, staged_valid_d;

  logic             active;
  logic             cycle_valid;
  logic             new_cycle;
  logic             window;
  logic             lat_done;
  logic [CYC_W-1:0] fetch_addr;

  // ACCTYPE[1] marks BOOT/USER; ACCTYPE[0] picks the user page region over the bootloader
  assign active      = ACCTYPE[1];
  assign cycle_valid = (BOUTCYCLENUM != INVALID_CYCLE);
  assign new_cycle   = active && cycle_valid && (BOUTCYCLENUM != last_cycle_q);
  assign window      = active && cycle_valid && (BOUTTICKS == DATA_TICK);
  assign fetch_addr  = (ACCTYPE[0] ? PAGE_BASE : BOOT_BASE) + BOUTCYCLENUM;

  bubble_fetch_latency_counter #(
    .W (LAT_W)
  ) u_lat (
    .clk_i      (MCLK),
    .rst_i      (RESET),
    .load_i     (new_cycle),
    .load_val_i (LAT_W'(RAM_LATENCY)),
    .count_i    (state_q == S_WAIT),
    .done_o     (lat_done)
  );

  // State register
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a new cycle number always (re)starts a fetch, leaving BOOT/USER abandons it
  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (new_cycle) state_d = S_WAIT;
        S_WAIT:  if (new_cycle) state_d = S_WAIT;
                 else if (lat_done) state_d = S_READY;
        S_READY: if (new_cycle) state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs and datapath; a nibble staged for an older cycle number never reaches the window
  always_comb begin
    rd_en_d        = new_cycle;
    rd_addr_d      = new_cycle ? fetch_addr : rd_addr_q;
    busy_d         = (state_d == S_WAIT);
    staged_d       = staged_q;
    staged_valid_d = staged_valid_q;
    ndout_d        = 4'b1111;
    underrun_d     = underrun_q;
    if (!active || new_cycle) begin
      staged_valid_d = 1'b0;
    end else if ((state_q == S_WAIT) && lat_done) begin
      staged_d       = RD_DATA;
      staged_valid_d = 1'b1;
    end
    if (window) begin
      if (staged_valid_q && !new_cycle) begin
        ndout_d = ~staged_q;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  // Registered outputs and staging; last_cycle follows the input every cycle
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      last_cycle_q   <= INVALID_CYCLE;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      busy_q         <= 1'b0;
      ndout_q        <= 4'b1111;
      underrun_q     <= 1'b0;
      staged_q       <= 4'b0000;
      staged_valid_q <= 1'b0;
    end else begin
      last_cycle_q   <= BOUTCYCLENUM;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      busy_q         <= busy_d;
      ndout_q        <= ndout_d;
      underrun_q     <= underrun_d;
      staged_q       <= staged_d;
      staged_valid_q <= staged_valid_d;
    end
  end

  assign RD_EN    = rd_en_q;
  assign RD_ADDR  = rd_addr_q;
  assign BUSY     = busy_q;
  assign nDOUT    = ndout_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_bubble_output_serializer.sv
// tb/tb_bubble_output_serializer.sv - randomized model-checked bench for two RAM latencies
module tb_bubble_output_serializer;
  import bubble_output_serializer_pkg::*;

  localparam int N = 2;
  localparam logic [12:0] INV = 13'd8191;

  logic        mclk = 1'b0;
  logic        reset;
  logic [2:0]  acctype;
  logic [12:0] num;
  logic [1:0]  ticks;
  logic        rd_en    [N];
  logic [12:0] rd_addr  [N];
  logic [3:0]  rd_data  [N];
  logic [3:0]  ndout    [N];
  logic        underrun [N];
  logic        busy     [N];

  always #5 mclk = ~mclk;

  bubble_output_serializer #(.RAM_LATENCY(2)) u_lat2 (
    .MCLK(mclk), .RESET(reset), .ACCTYPE(acctype), .BOUTCYCLENUM(num), .BOUTTICKS(ticks),
    .RD_EN(rd_en[0]), .RD_ADDR(rd_addr[0]), .RD_DATA(rd_data[0]),
    .nDOUT(ndout[0]), .UNDERRUN(underrun[0]), .BUSY(busy[0])
  );

  bubble_output_serializer #(.RAM_LATENCY(4)) u_lat4 (
    .MCLK(mclk), .RESET(reset), .ACCTYPE(acctype), .BOUTCYCLENUM(num), .BOUTTICKS(ticks),
    .RD_EN(rd_en[1]), .RD_ADDR(rd_addr[1]), .RD_DATA(rd_data[1]),
    .nDOUT(ndout[1]), .UNDERRUN(underrun[1]), .BUSY(busy[1])
  );

  int compared = 0;
  int mismatched = 0;
  int cyc_n = 0;
  bit started = 0;

  logic        exp_rd_en [N];
  logic [12:0] exp_addr  [N];
  logic [3:0]  exp_nd    [N];
  logic        exp_und   [N];
  logic        exp_busy  [N];

  logic [12:0] m_last;
  bit          m_live  [N];
  int          m_fcyc  [N];
  logic [12:0] m_faddr [N];

  bit          ram_v [N][8];
  logic [12:0] ram_a [N][8];

  logic [2:0] accs [5] = '{3'b000, 3'b001, 3'b100, 3'b110, 3'b111};

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [3:0] mem(input logic [12:0] a);
    return 4'b1010 ^ a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  task automatic chk(input string name, input int i, input logic [12:0] act, input logic [12:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s lat%0d cycle %0d: got %0h expected %0h", name, lat_of(i), cyc_n, act, exp);
    end
  endtask

  // Timeline model: a fetch detected at cycle c is usable in the window from cycle c+L+2 on
  task automatic model_step(input int k, input logic rst, input logic [2:0] acc,
                            input logic [12:0] n, input logic [1:0] t);
    bit act, nc, win, avail;
    logic [12:0] addr;
    if (rst) begin
      m_last = INV;
      for (int i = 0; i < N; i++) begin
        m_live[i] = 0; exp_rd_en[i] = 0; exp_addr[i] = '0;
        exp_nd[i] = 4'b1111; exp_und[i] = 0; exp_busy[i] = 0;
      end
    end else begin
      act  = acc[1];
      nc   = act && (n != INV) && (n != m_last);
      win  = act && (n != INV) && (t == 2'b10);
      addr = 13'((acc[0] ? 4352 : 0) + int'(n));
      for (int i = 0; i < N; i++) begin
        avail = m_live[i] && (k >= m_fcyc[i] + lat_of(i) + 2) && !nc;
        exp_nd[i] = (win && avail) ? ~mem(m_faddr[i]) : 4'b1111;
        if (win && !avail) exp_und[i] = 1;
        if (!act) m_live[i] = 0;
        if (nc) begin
          m_live[i] = 1; m_fcyc[i] = k; m_faddr[i] = addr; exp_addr[i] = addr;
        end
        exp_rd_en[i] = nc;
        exp_busy[i]  = m_live[i] && (k + 1 <= m_fcyc[i] + lat_of(i) + 1);
      end
      m_last = n;
    end
  endtask

  // One MCLK cycle: drive inputs and RAM data, advance the model, then record new read requests
  task automatic cyc(input logic rst, input logic [2:0] acc, input logic [12:0] n, input logic [1:0] t);
    int k = cyc_n;
    int s;
    reset = rst; acctype = acc; num = n; ticks = t;
    for (int i = 0; i < N; i++) begin
      s = k % 8;
      rd_data[i] = ram_v[i][s] ? mem(ram_a[i][s]) : 4'($urandom);
      ram_v[i][s] = 0;
    end
    model_step(k, rst, acc, n, t);
    started = 1;
    @(negedge mclk);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (rd_en[i] === 1'b1) begin
        s = (cyc_n + lat_of(i)) % 8;
        ram_v[i][s] = 1;
        ram_a[i][s] = rd_addr[i];
      end
    end
  endtask

  // Every-cycle comparison of both DUTs against the model
  always @(negedge mclk) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        chk("RD_EN", i, 13'(rd_en[i]), 13'(exp_rd_en[i]));
        chk("RD_ADDR", i, rd_addr[i], exp_addr[i]);
        chk("nDOUT", i, 13'(ndout[i]), 13'(exp_nd[i]));
        chk("UNDERRUN", i, 13'(underrun[i]), 13'(exp_und[i]));
        chk("BUSY", i, 13'(busy[i]), 13'(exp_busy[i]));
      end
    end
  end

  initial begin
    logic [2:0] a;
    logic [12:0] n;
    logic [1:0] t;
    int r;
    for (int i = 0; i < N; i++) for (int s = 0; s < 8; s++) ram_v[i][s] = 0;

    for (int j = 0; j < 3; j++) cyc(1, accs[$urandom_range(0, 4)], 13'($urandom), 2'($urandom));
    for (int i = 0; i < N; i++) begin
      chk("lit_reset_nDOUT", i, 13'(ndout[i]), 13'h000F);
      chk("lit_reset_RD_EN", i, 13'(rd_en[i]), 13'h0);
      chk("lit_reset_UNDERRUN", i, 13'(underrun[i]), 13'h0);
      chk("lit_reset_BUSY", i, 13'(busy[i]), 13'h0);
    end

    cyc(0, ACC_BOOT, 13'd0, 2'b00);
    for (int i = 0; i < N; i++) begin
      chk("lit_boot0_RD_EN", i, 13'(rd_en[i]), 13'h1);
      chk("lit_boot0_RD_ADDR", i, rd_addr[i], 13'd0);
    end
    for (int j = 0; j < 5; j++) cyc(0, ACC_BOOT, 13'd0, 2'b00);
    cyc(0, ACC_BOOT, 13'd0, 2'b10);
    for (int i = 0; i < N; i++) chk("lit_boot0_nDOUT", i, 13'(ndout[i]), 13'(4'b0101));
    cyc(0, ACC_BOOT, 13'd0, 2'b11);
    for (int i = 0; i < N; i++) chk("lit_offtick_nDOUT", i, 13'(ndout[i]), 13'(4'b1111));
    cyc(0, ACC_BOOT, 13'd1, 2'b00);
    for (int i = 0; i < N; i++) chk("lit_boot1_RD_ADDR", i, rd_addr[i], 13'd1);
    for (int j = 0; j < 5; j++) cyc(0, ACC_BOOT, 13'd1, 2'b00);
    cyc(0, ACC_BOOT, 13'd1, 2'b10);
    for (int i = 0; i < N; i++) chk("lit_boot1_nDOUT", i, 13'(ndout[i]), 13'(4'b0100));

    cyc(0, ACC_USER, 13'd583, 2'b00);
    for (int i = 0; i < N; i++) chk("lit_user583_RD_ADDR", i, rd_addr[i], 13'd4935);
    for (int j = 0; j < 6; j++) cyc(0, ACC_USER, 13'd583, 2'b01);
    cyc(0, ACC_USER, INV, 2'b00);
    for (int j = 0; j < 4; j++) begin
      cyc(0, ACC_USER, INV, 2'b10);
      for (int i = 0; i < N; i++) begin
        chk("lit_invalid_RD_EN", i, 13'(rd_en[i]), 13'h0);
        chk("lit_invalid_nDOUT", i, 13'(ndout[i]), 13'(4'b1111));
        chk("lit_invalid_UNDERRUN", i, 13'(underrun[i]), 13'h0);
      end
    end

    cyc(0, ACC_USER, 13'd700, 2'b00);
    for (int j = 0; j < 3; j++) cyc(0, ACC_USER, 13'd700, 2'b00);
    cyc(0, ACC_USER, 13'd700, 2'b10);
    chk("lit_late_nDOUT", 0, 13'(ndout[0]), 13'(4'b0001));
    chk("lit_late_UNDERRUN", 0, 13'(underrun[0]), 13'h0);
    chk("lit_late_nDOUT", 1, 13'(ndout[1]), 13'(4'b1111));
    chk("lit_late_UNDERRUN", 1, 13'(underrun[1]), 13'h1);
    for (int j = 0; j < 8; j++) cyc(0, ACC_USER, 13'd700, 2'(j));
    chk("lit_sticky_UNDERRUN", 1, 13'(underrun[1]), 13'h1);

    cyc(0, ACC_USER, 13'd800, 2'b00);
    cyc(0, ACC_USER, 13'd800, 2'b00);
    cyc(0, ACC_USER, 13'd801, 2'b00);
    for (int i = 0; i < N; i++) begin
      chk("lit_reissue_RD_EN", i, 13'(rd_en[i]), 13'h1);
      chk("lit_reissue_RD_ADDR", i, rd_addr[i], 13'd5153);
    end
    for (int j = 0; j < 6; j++) cyc(0, ACC_USER, 13'd801, 2'b00);
    cyc(0, ACC_USER, 13'd801, 2'b10);
    for (int i = 0; i < N; i++) chk("lit_reissue_nDOUT", i, 13'(ndout[i]), 13'(4'b0010));

    cyc(0, ACC_USER, 13'd900, 2'b00);
    cyc(0, ACC_RST, 13'd900, 2'b10);
    for (int i = 0; i < N; i++) begin
      chk("lit_abort_BUSY", i, 13'(busy[i]), 13'h0);
      chk("lit_abort_nDOUT", i, 13'(ndout[i]), 13'(4'b1111));
    end
    for (int j = 0; j < 4; j++) begin
      cyc(0, ACC_RST, 13'(901 + j), 2'b10);
      for (int i = 0; i < N; i++) chk("lit_abort_RD_EN", i, 13'(rd_en[i]), 13'h0);
    end

    cyc(1, ACC_USER, 13'd0, 2'b00);
    cyc(1, ACC_USER, 13'd0, 2'b00);
    for (int i = 0; i < N; i++) chk("lit_clear_UNDERRUN", i, 13'(underrun[i]), 13'h0);

    a = ACC_BOOT; n = 13'd0; t = 2'b00;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 39) == 0) a = accs[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 5) n = 13'($urandom_range(0, 15));
        else if (r < 7) n = INV;
        else if (r < 9) n = 13'($urandom_range(3840, 8190));
        else n = 13'($urandom);
      end
      if ($urandom_range(0, 15) == 0) t = 2'($urandom);
      else t = t + 2'd1;
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, a, n, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
